// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the Pong design.
//   game_state_t : match sequencer states used by game_controller
//   X_RESOLUTION : horizontal display resolution in pixels
//   Y_RESOLUTION : vertical display resolution in pixels
//   SCORE_W      : width of each player's score
//   LVL_W        : width of the ball speed level
//   CNT_W        : width of the shared serve/hold down-counter
//   lvl_inc_sat  : increments a speed level, saturating at a given maximum
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        GAME_OVER
    } game_state_t;

    localparam int X_RESOLUTION = 640;
    localparam int Y_RESOLUTION = 480;
    localparam int SCORE_W      = 4;
    localparam int LVL_W        = 3;
    localparam int CNT_W        = 25;

    function automatic logic [LVL_W-1:0] lvl_inc_sat(
        input logic [LVL_W-1:0] cur,
        input logic [LVL_W-1:0] max_lvl
    );
        return (cur >= max_lvl) ? max_lvl : cur + LVL_W'(1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Single-stage rising-edge detector. The previous sample is registered; the
// pulse is high for the one cycle in which d is high and its previous sample
// was low, so a level held for many cycles yields exactly one pulse.
// Ports:
//   clk   in  1  clock
//   reset in  1  synchronous, active-high reset (clears the previous sample)
//   d     in  1  level input
//   pulse out 1  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Match sequencer for Pong. Sits between the player inputs and the Ball
// module: consumes Ball's point and paddle-hit events, drives Ball's game_on,
// active-low re-serve reset, serve direction and speed level, keeps both
// scores and declares the winner.
// Parameters:
//   WIN_SCORE      points needed to win (1..15)
//   SERVE_DELAY    cycles the ball is held still before launch
//   POINT_HOLD     cycles ball_reset_n is held low after a point (>=2)
//   HITS_PER_LEVEL paddle hits per lvl increment
//   MAX_LVL        lvl saturation value (<=7)
// Ports:
//   clk           in  1  master clock
//   reset         in  1  synchronous, active-high reset
//   start         in  1  debounced start button, rising edge acts
//   player1_point in  1  from Ball, level
//   player2_point in  1  from Ball, level
//   paddle_hit    in  1  from Ball, level
//   game_on       out 1  high only while the ball is in play
//   ball_reset_n  out 1  low re-centres the ball; Ball samples dir/lvl then
//   dir           out 1  serve direction, 1 = toward player 2
//   lvl           out 3  speed level
//   score1        out 4  player 1 score
//   score2        out 4  player 2 score
//   game_over     out 1  high once a player has reached WIN_SCORE
//   winner        out 1  0 = player 1, 1 = player 2; valid while game_over
// -----------------------------------------------------------------------------
module game_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 7,
    parameter int SERVE_DELAY    = 25_000_000,
    parameter int POINT_HOLD     = 4,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_LVL        = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               player1_point,
    input  logic               player2_point,
    input  logic               paddle_hit,
    output logic               game_on,
    output logic               ball_reset_n,
    output logic               dir,
    output logic [LVL_W-1:0]   lvl,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner
);

    // The rally counter only needs to count 0..HITS_PER_LEVEL-1.
    localparam int RALLY_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    // The counter is loaded with (duration - 1) and the state is left when it
    // reads zero, so SERVE and POINT each last exactly their duration.
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'((SERVE_DELAY > 0) ? SERVE_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'((POINT_HOLD > 0) ? POINT_HOLD - 1 : 0);
    localparam logic [RALLY_W-1:0] RALLY_LAST = RALLY_W'((HITS_PER_LEVEL > 0) ? HITS_PER_LEVEL - 1 : 0);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [LVL_W-1:0]   MAX_VAL    = LVL_W'(MAX_LVL);

    game_state_t        state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [RALLY_W-1:0] rally, rally_next;
    logic [SCORE_W-1:0] score1_next, score2_next;
    logic [LVL_W-1:0]   lvl_next;
    logic               dir_next, winner_next;
    logic               game_on_next, ball_reset_n_next, game_over_next;

    logic start_ev, p1_ev, p2_ev, hit_ev;

    // Edge detectors run in every state, so a point level still high when the
    // controller returns to PLAY cannot score a second time.
    rise_detect u_start_edge (.clk(clk), .reset(reset), .d(start),         .pulse(start_ev));
    rise_detect u_p1_edge    (.clk(clk), .reset(reset), .d(player1_point), .pulse(p1_ev));
    rise_detect u_p2_edge    (.clk(clk), .reset(reset), .d(player2_point), .pulse(p2_ev));
    rise_detect u_hit_edge   (.clk(clk), .reset(reset), .d(paddle_hit),    .pulse(hit_ev));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rally        <= '0;
            score1       <= '0;
            score2       <= '0;
            lvl          <= '0;
            dir          <= 1'b1;
            winner       <= 1'b0;
            game_on      <= 1'b0;
            ball_reset_n <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            rally        <= rally_next;
            score1       <= score1_next;
            score2       <= score2_next;
            lvl          <= lvl_next;
            dir          <= dir_next;
            winner       <= winner_next;
            game_on      <= game_on_next;
            ball_reset_n <= ball_reset_n_next;
            game_over    <= game_over_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        rally_next  = rally;
        score1_next = score1;
        score2_next = score2;
        lvl_next    = lvl;
        dir_next    = dir;
        winner_next = winner;

        case (state)
            IDLE: begin
                if (start_ev) begin
                    state_next  = SERVE;
                    cnt_next    = SERVE_LOAD;
                    score1_next = '0;
                    score2_next = '0;
                    lvl_next    = '0;
                    rally_next  = '0;
                    dir_next    = 1'b1;
                    winner_next = 1'b0;
                end
            end

            SERVE: begin
                if (cnt == '0) begin
                    state_next = PLAY;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            PLAY: begin
                // Point events win over a paddle hit in the same cycle; the
                // loser of the point receives the next serve.
                if (p1_ev || p2_ev) begin
                    state_next = POINT;
                    cnt_next   = POINT_LOAD;
                    lvl_next   = '0;
                    rally_next = '0;
                    if (p1_ev && !p2_ev) begin
                        if (score1 < WIN_VAL) begin
                            score1_next = score1 + SCORE_W'(1);
                        end
                        dir_next = 1'b1;
                    end else if (p2_ev && !p1_ev) begin
                        if (score2 < WIN_VAL) begin
                            score2_next = score2 + SCORE_W'(1);
                        end
                        dir_next = 1'b0;
                    end
                end else if (hit_ev) begin
                    if (rally == RALLY_LAST) begin
                        rally_next = '0;
                        lvl_next   = lvl_inc_sat(lvl, MAX_VAL);
                    end else begin
                        rally_next = rally + RALLY_W'(1);
                    end
                end
            end

            POINT: begin
                if (cnt == '0) begin
                    if ((score1 == WIN_VAL) || (score2 == WIN_VAL)) begin
                        state_next  = GAME_OVER;
                        winner_next = (score2 == WIN_VAL);
                    end else begin
                        state_next = SERVE;
                        cnt_next   = SERVE_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            GAME_OVER: begin
                if (start_ev) begin
                    state_next  = IDLE;
                    score1_next = '0;
                    score2_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Ball-facing control outputs are registered copies of the next state,
        // so they always line up with the state register.
        game_on_next      = (state_next == PLAY);
        ball_reset_n_next = (state_next == SERVE) || (state_next == PLAY);
        game_over_next    = (state_next == GAME_OVER);
    end

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Directed bench for game_controller with SERVE_DELAY=8, POINT_HOLD=4,
// WIN_SCORE=3, HITS_PER_LEVEL=2. Inputs change just after the falling edge
// and outputs are sampled on the falling edge, midway between active edges.
// -----------------------------------------------------------------------------
module tb_game_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       player1_point;
    logic       player2_point;
    logic       paddle_hit;
    logic       game_on;
    logic       ball_reset_n;
    logic       dir;
    logic [2:0] lvl;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    int checks;
    int failures;

    // Reset-state output vector: only dir is high.
    localparam logic [15:0] RESET_OUTS = 16'h2000;

    game_controller #(
        .WIN_SCORE(3),
        .SERVE_DELAY(8),
        .POINT_HOLD(4),
        .HITS_PER_LEVEL(2),
        .MAX_LVL(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .player1_point(player1_point),
        .player2_point(player2_point),
        .paddle_hit(paddle_hit),
        .game_on(game_on),
        .ball_reset_n(ball_reset_n),
        .dir(dir),
        .lvl(lvl),
        .score1(score1),
        .score2(score2),
        .game_over(game_over),
        .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {game_on, ball_reset_n, dir, lvl, score1, score2, game_over, winner};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start pulse from IDLE and wait until the ball is in play (1 + 8 cycles).
    task automatic go_play();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        checks++;
        if (outs() !== RESET_OUTS) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", outs(), RESET_OUTS);
        end
        reset = 1'b0;
        tick(2);
        checks++;
        if (outs() !== RESET_OUTS) begin
            failures++;
            $display("[TB] FAIL idle_hold: got %h expected %h", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_serve();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({game_on, ball_reset_n} !== 2'b01) begin
                failures++;
                $display("[TB] FAIL serve_cycle_%0d: got game_on/ball_reset_n %b expected 01", k, {game_on, ball_reset_n});
            end
            tick(1);
        end
        checks++;
        if ({game_on, ball_reset_n} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL serve_to_play: got game_on/ball_reset_n %b expected 11", {game_on, ball_reset_n});
        end
    endtask

    task automatic test_point_hold();
        player1_point = 1'b1;
        tick(1);
        checks++;
        if ({score1, score2, dir, lvl} !== {4'd1, 4'd0, 1'b1, 3'd0}) begin
            failures++;
            $display("[TB] FAIL p1_point_score: got s1=%0d s2=%0d dir=%0b lvl=%0d expected s1=1 s2=0 dir=1 lvl=0", score1, score2, dir, lvl);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({game_on, ball_reset_n} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL point_hold_%0d: got game_on/ball_reset_n %b expected 00", k, {game_on, ball_reset_n});
            end
            if (k < 4) tick(1);
        end
        tick(1);
        checks++;
        if ({game_on, ball_reset_n} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL point_to_serve: got game_on/ball_reset_n %b expected 01", {game_on, ball_reset_n});
        end
        // Keep the level high for 20 cycles in total, well into the next PLAY.
        tick(15);
        checks++;
        if ({game_on, score1} !== {1'b1, 4'd1}) begin
            failures++;
            $display("[TB] FAIL held_level_once: got game_on=%0b s1=%0d expected game_on=1 s1=1", game_on, score1);
        end
        player1_point = 1'b0;
        tick(1);
    endtask

    task automatic test_paddle_levels();
        logic [2:0] exp_lvl [5];
        exp_lvl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
        for (int k = 0; k < 5; k++) begin
            paddle_hit = 1'b1;
            tick(1);
            paddle_hit = 1'b0;
            tick(1);
            checks++;
            if ({game_on, lvl} !== {1'b1, exp_lvl[k]}) begin
                failures++;
                $display("[TB] FAIL hit_%0d_lvl: got game_on=%0b lvl=%0d expected game_on=1 lvl=%0d", k + 1, game_on, lvl, exp_lvl[k]);
            end
        end
        player2_point = 1'b1;
        tick(1);
        player2_point = 1'b0;
        checks++;
        if ({score1, score2, dir, lvl} !== {4'd1, 4'd1, 1'b0, 3'd0}) begin
            failures++;
            $display("[TB] FAIL p2_point_lvl_dir: got s1=%0d s2=%0d dir=%0b lvl=%0d expected s1=1 s2=1 dir=0 lvl=0", score1, score2, dir, lvl);
        end
        tick(12);
        checks++;
        if (game_on !== 1'b1) begin
            failures++;
            $display("[TB] FAIL p2_reserve_play: got game_on=%0b expected 1", game_on);
        end
    endtask

    task automatic test_simultaneous_points();
        player1_point = 1'b1;
        player2_point = 1'b1;
        tick(1);
        player1_point = 1'b0;
        player2_point = 1'b0;
        checks++;
        if ({ball_reset_n, score1, score2, dir, lvl} !== {1'b0, 4'd1, 4'd1, 1'b0, 3'd0}) begin
            failures++;
            $display("[TB] FAIL both_points: got brn=%0b s1=%0d s2=%0d dir=%0b lvl=%0d expected brn=0 s1=1 s2=1 dir=0 lvl=0", ball_reset_n, score1, score2, dir, lvl);
        end
        tick(4);
        checks++;
        if ({game_on, ball_reset_n} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL both_points_serve: got game_on/ball_reset_n %b expected 01", {game_on, ball_reset_n});
        end
        // A point pulse during SERVE must be ignored.
        player1_point = 1'b1;
        tick(1);
        player1_point = 1'b0;
        tick(7);
        checks++;
        if ({game_on, score1, score2} !== {1'b1, 4'd1, 4'd1}) begin
            failures++;
            $display("[TB] FAIL serve_point_ignored: got game_on=%0b s1=%0d s2=%0d expected game_on=1 s1=1 s2=1", game_on, score1, score2);
        end
    endtask

    task automatic test_win();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        go_play();
        for (int i = 1; i <= 3; i++) begin
            player2_point = 1'b1;
            tick(1);
            player2_point = 1'b0;
            checks++;
            if ({score1, score2} !== {4'd0, 4'(i)}) begin
                failures++;
                $display("[TB] FAIL win_point_%0d: got s1=%0d s2=%0d expected s1=0 s2=%0d", i, score1, score2, i);
            end
            if (i < 3) tick(12);
        end
        tick(3);
        checks++;
        if (game_over !== 1'b0) begin
            failures++;
            $display("[TB] FAIL win_hold_not_over: got game_over=%0b expected 0", game_over);
        end
        tick(1);
        checks++;
        if ({game_on, ball_reset_n, game_over, winner} !== 4'b0011) begin
            failures++;
            $display("[TB] FAIL game_over_entry: got on/brn/over/winner %b expected 0011", {game_on, ball_reset_n, game_over, winner});
        end
        player1_point = 1'b1;
        tick(1);
        player1_point = 1'b0;
        player2_point = 1'b1;
        tick(1);
        player2_point = 1'b0;
        paddle_hit = 1'b1;
        tick(1);
        paddle_hit = 1'b0;
        tick(1);
        checks++;
        if ({game_on, game_over, winner, score1, score2} !== {3'b011, 4'd0, 4'd3}) begin
            failures++;
            $display("[TB] FAIL game_over_ignores: got on=%0b over=%0b win=%0b s1=%0d s2=%0d expected on=0 over=1 win=1 s1=0 s2=3", game_on, game_over, winner, score1, score2);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++;
        if ({game_on, ball_reset_n, game_over, score1, score2} !== {3'b000, 4'd0, 4'd0}) begin
            failures++;
            $display("[TB] FAIL restart_idle: got on=%0b brn=%0b over=%0b s1=%0d s2=%0d expected all 0", game_on, ball_reset_n, game_over, score1, score2);
        end
        tick(3);
        checks++;
        if ({game_on, ball_reset_n} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_no_autostart: got game_on/ball_reset_n %b expected 00", {game_on, ball_reset_n});
        end
    endtask

    task automatic test_mid_reset();
        // Reset while the serve counter reads 3.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        checks++;
        if (outs() !== RESET_OUTS) begin
            failures++;
            $display("[TB] FAIL reset_in_serve: got %h expected %h", outs(), RESET_OUTS);
        end
        reset = 1'b0;
        tick(2);
        checks++;
        if (outs() !== RESET_OUTS) begin
            failures++;
            $display("[TB] FAIL after_serve_reset_idle: got %h expected %h", outs(), RESET_OUTS);
        end
        go_play();
        player2_point = 1'b1;
        tick(1);
        player2_point = 1'b0;
        tick(12);
        for (int k = 0; k < 2; k++) begin
            paddle_hit = 1'b1;
            tick(1);
            paddle_hit = 1'b0;
            tick(1);
        end
        // A start pulse during PLAY must be ignored.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        checks++;
        if ({game_on, lvl, score2, dir} !== {1'b1, 3'd1, 4'd1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL play_before_reset: got on=%0b lvl=%0d s2=%0d dir=%0b expected on=1 lvl=1 s2=1 dir=0", game_on, lvl, score2, dir);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (outs() !== RESET_OUTS) begin
            failures++;
            $display("[TB] FAIL reset_in_play: got %h expected %h", outs(), RESET_OUTS);
        end
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        start         = 1'b0;
        player1_point = 1'b0;
        player2_point = 1'b0;
        paddle_hit    = 1'b0;

        test_reset();
        test_serve();
        test_point_hold();
        test_paddle_levels();
        test_simultaneous_points();
        test_win();
        test_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
